text_writer: RTL
================

# text_writer

Write-side companion to the text-mode display buffer. Consumes a byte stream of ASCII characters from the LC3 console path over a valid/ready handshake and turns it into single-cell writes into the 80×30 character buffer. It tracks a cursor, interprets a small set of control codes, and clears the screen or line as needed. The buffer address format is {row[4:0], col[6:0]}, which is the same packing the display scan side uses to read (scanline[8:4], dot[9:3]).

## Interface
- CHAR_W, 8: width of a character code on in_data and wr_data.
- FILL_CHAR, 8'h20: code written into cleared cells.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a character to consume.
- in_data  in  CHAR_W  character code.
- in_ready  out  1  block can accept a character this cycle.
- wr_en  out  1  buffer write strobe, one cell per cycle.
- wr_addr  out  12  {row[4:0], col[6:0]}; row 0–29, col 0–79.
- wr_data  out  CHAR_W  code to store.
- cur_row  out  5  current cursor row.
- cur_col  out  7  current cursor column.

## Operation
- Transfer: a character is accepted on an edge where in_valid && in_ready are both high. While in_ready is low, in_valid is ignored and the source holds its data.
- States:
  - CLR_ALL: writes FILL_CHAR to all 2400 cells, row-major from {0,0} to {29,79}. Columns 80–127 are never addressed.
  - IDLE: in_ready=1.
  - CLR_LINE: writes FILL_CHAR to cols 0–79 of cur_row.
- Reset enters CLR_ALL with cursor (0,0).
- Printable character (0x20–0x7E):
  - Write it at (cur_row, cur_col), then increment cur_col.
  - At col 79 the cursor moves to col 0 of the next row instead (row advance).
- Control codes:
  - 0x0A LF: col←0, row advance.
  - 0x0D CR: col←0, no write.
  - 0x08 BS: if col>0, col←col−1 and write FILL_CHAR at the new col. At col 0 it is a no-op.
  - 0x0C FF: cursor←(0,0), enter CLR_ALL.
  - Any other code (0x00–0x1F, 0x7F–0xFF): consumed and dropped, no write.
- Row advance: row 29 wraps to row 0. There is no scrolling.
- All outputs are registered.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, in_ready=0, cur_row=0, cur_col=0.
- CLR_ALL:
  - wr_en is high for exactly 2400 consecutive cycles, starting at the first rising edge after rst_n deasserts.
  - in_ready goes high on the following edge.
- Printable or BS accepted at edge N:
  - wr_en/wr_addr/wr_data are valid in the cycle after edge N.
  - cur_row/cur_col update at edge N.
  - in_ready stays high unless a row advance occurred.
- Back-to-back: one character per cycle is sustained in IDLE.
- CLR_LINE entered at edge N:
  - in_ready is low from edge N.
  - 80 clear writes follow the character's own write, if there is one.
  - in_ready returns high on the edge after the col-79 clear.
- FF accepted at edge N: same 2400-cycle sequence as reset, starting at edge N+1.
- Asynchronous reset mid-operation:
  - Aborts any clear immediately.
  - Outputs go to their reset values.
  - CLR_ALL restarts from {0,0}.

## Configuration
- TEXT_WRITER_LINE_CLEAR_EN
- Defined:
  - Every row advance enters CLR_LINE for the new row.
  - The row is blanked before any text is written to it.
- Undefined:
  - The CLR_LINE state is not built.
  - A row advance only updates the cursor; old content stays until overwritten.
  - in_ready stays high through a row advance.
  - CLR_ALL (reset and FF) is unaffected.

## Test plan
- Release reset → 2400 writes of 8'h20 in order: {0,0}…{0,79}, {1,0}…{29,79}. No address has col≥80. in_ready rises one cycle after the last write.
- Send "AB" back-to-back from IDLE → writes 0x41@{0,0} and 0x42@{0,1} on consecutive cycles. cursor=(0,2). in_ready stays high.
- Place the cursor at (3,79) and send 'x':
  - With LINE_CLEAR_EN: write 0x78@{3,79}, then 80 fill writes on row 4. in_ready low for 81 cycles. cursor=(4,0).
  - Without LINE_CLEAR_EN: no fill writes; cursor=(4,0).
- LF at row 29 → cursor=(0,0); with LINE_CLEAR_EN, row 0 is blanked.
- Apply the following, in order:
  - BS at (5,0): no write, cursor unchanged.
  - BS at (5,10): write 0x20@{5,9}, cursor=(5,9).
  - 0x07: no write, consumed.
  - CR: cursor=(5,0), no write.
- FF mid-stream, then assert rst_n low at write 1000 of the FF clear → outputs are at their reset values while rst_n is low. After release, a full 2400-write clear from {0,0} follows.

Source files
------------

// File: rtl/text_writer.sv
// Character stream to 80x30 text buffer writer: cursor tracking, control codes, screen/line clears.
// Optional TEXT_WRITER_LINE_CLEAR_EN blanks each new row on row advance.
module text_writer #(
   parameter int                CHAR_W    = 8,
   parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'('h20)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [CHAR_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [11:0]       wr_addr,
   output logic [CHAR_W-1:0] wr_data,
   output logic [4:0]        cur_row,
   output logic [6:0]        cur_col
);

   localparam logic [4:0] LAST_ROW = 5'd29;
   localparam logic [6:0] LAST_COL = 7'd79;

   localparam logic [CHAR_W-1:0] C_BS = CHAR_W'('h08);
   localparam logic [CHAR_W-1:0] C_LF = CHAR_W'('h0A);
   localparam logic [CHAR_W-1:0] C_FF = CHAR_W'('h0C);
   localparam logic [CHAR_W-1:0] C_CR = CHAR_W'('h0D);
   localparam logic [CHAR_W-1:0] C_LO = CHAR_W'('h20);
   localparam logic [CHAR_W-1:0] C_HI = CHAR_W'('h7E);

   typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

   state_t     state;
   logic [4:0] clr_row;
   logic [6:0] clr_col;

   logic       accept, printable, row_adv;
   logic [4:0] row_next;

   always_comb begin
      accept    = (state == IDLE) && in_valid && in_ready;
      printable = (in_data >= C_LO) && (in_data <= C_HI);
      row_adv   = accept && ((printable && cur_col == LAST_COL) || in_data == C_LF);
      row_next  = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CLR_ALL;
         clr_row  <= '0;
         clr_col  <= '0;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         cur_row  <= '0;
         cur_col  <= '0;
      end else begin
         case (state)
            CLR_ALL: begin
               in_ready <= 1'b0;
               wr_en    <= 1'b1;
               wr_addr  <= {clr_row, clr_col};
               wr_data  <= FILL_CHAR;
               if (clr_col == LAST_COL) begin
                  clr_col <= '0;
                  if (clr_row == LAST_ROW) begin
                     clr_row <= '0;
                     state   <= IDLE;
                  end else begin
                     clr_row <= clr_row + 5'd1;
                  end
               end else begin
                  clr_col <= clr_col + 7'd1;
               end
            end
`ifdef TEXT_WRITER_LINE_CLEAR_EN
            CLR_LINE: begin
               in_ready <= 1'b0;
               wr_en    <= 1'b1;
               wr_addr  <= {cur_row, clr_col};
               wr_data  <= FILL_CHAR;
               if (clr_col == LAST_COL) begin
                  clr_col <= '0;
                  state   <= IDLE;
               end else begin
                  clr_col <= clr_col + 7'd1;
               end
            end
`endif
            default: begin
               // in_ready rises one edge after any clear finishes
               wr_en    <= 1'b0;
               in_ready <= 1'b1;
               state    <= IDLE;
               if (accept) begin
                  if (printable) begin
                     wr_en   <= 1'b1;
                     wr_addr <= {cur_row, cur_col};
                     wr_data <= in_data;
                     cur_col <= (cur_col == LAST_COL) ? 7'd0 : cur_col + 7'd1;
                  end else if (in_data == C_LF || in_data == C_CR) begin
                     cur_col <= '0;
                  end else if (in_data == C_BS) begin
                     if (cur_col != 7'd0) begin
                        cur_col <= cur_col - 7'd1;
                        wr_en   <= 1'b1;
                        wr_addr <= {cur_row, cur_col - 7'd1};
                        wr_data <= FILL_CHAR;
                     end
                  end else if (in_data == C_FF) begin
                     cur_row  <= '0;
                     cur_col  <= '0;
                     clr_row  <= '0;
                     clr_col  <= '0;
                     in_ready <= 1'b0;
                     state    <= CLR_ALL;
                  end
                  if (row_adv) begin
                     cur_row <= row_next;
`ifdef TEXT_WRITER_LINE_CLEAR_EN
                     clr_col  <= '0;
                     in_ready <= 1'b0;
                     state    <= CLR_LINE;
`endif
                  end
               end
            end
         endcase
      end
   end

endmodule
